// File: rtl/stepper_axis_driver_if.sv
// Command handshake bundle for stepper_axis_driver: one move request
// (direction, step count, step period) per valid/ready transfer.
interface stepper_axis_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [31:0] cmd_steps;
    logic [31:0] cmd_period;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        output cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        input  cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_axis_driver.sv
// stepper_axis_driver: single-axis STEP/DIR pulse generator.
// Takes one move command over a valid/ready handshake, waits a DIR setup
// time, then issues step pulses at a fixed (clamped) period while tracking
// remaining steps and signed absolute position.
//
// Optional macro STEPPER_LIMIT_EN adds limit_min/limit_max inputs that block
// the next step toward an active end stop, plus a sticky limit_hit flag.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SETUP | DIR stable, STEP low, counting the DIR-to-STEP setup time
// HIGH  | STEP high for PULSE_W cycles
// LOW   | STEP low for the remainder of the step period
// DONE  | one-cycle done pulse, then back to IDLE
module stepper_axis_driver #(
    parameter int PULSE_W    = 100,
    parameter int MIN_PERIOD = 200,
    parameter int SETUP_CYC  = 50
) (
    input  logic                       clock,
    input  logic                       reset,
    stepper_axis_driver_if.slave       cmd,
    input  logic                       abort,
`ifdef STEPPER_LIMIT_EN
    input  logic                       limit_min,
    input  logic                       limit_max,
    output logic                       limit_hit,
`endif
    output logic                       step_out,
    output logic                       dir_out,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                steps_left,
    output logic signed [31:0]         position
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    // Timer reloads hold N-1 so a phase of N cycles expires on its N-th edge.
    localparam logic [31:0] SETUP_RELOAD = 32'(SETUP_CYC - 1);
    localparam logic [31:0] PULSE_RELOAD = 32'(PULSE_W - 1);
    localparam logic [31:0] PULSE_LEN    = 32'(PULSE_W);
    localparam logic [31:0] MIN_PER      = 32'(MIN_PERIOD);

    state_t             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic [31:0]        period_q, period_d;
    logic               dir_q, dir_d;
    logic [31:0]        steps_left_q, steps_left_d;
    logic signed [31:0] position_q, position_d;
    logic               limit_hit_q, limit_hit_d;

    logic               accept;
    logic               go_high;
    logic               blocked;

    assign accept = cmd.cmd_valid && cmd.cmd_ready;

`ifdef STEPPER_LIMIT_EN
    // Only the end stop in the direction of travel can block a step.
    assign blocked = dir_q ? limit_max : limit_min;
    assign limit_hit = limit_hit_q;
`else
    assign blocked = 1'b0;
`endif

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            period_q     <= '0;
            dir_q        <= 1'b0;
            steps_left_q <= '0;
            position_q   <= '0;
            limit_hit_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            period_q     <= period_d;
            dir_q        <= dir_d;
            steps_left_q <= steps_left_d;
            position_q   <= position_d;
            limit_hit_q  <= limit_hit_d;
        end
    end

    // Next-state, phase timer and step/position bookkeeping.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        period_d     = period_q;
        dir_d        = dir_q;
        steps_left_d = steps_left_q;
        position_d   = position_q;
        limit_hit_d  = limit_hit_q;
        go_high      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dir_d        = cmd.cmd_dir;
                    steps_left_d = cmd.cmd_steps;
                    period_d     = (cmd.cmd_period < MIN_PER) ? MIN_PER : cmd.cmd_period;
                    limit_hit_d  = 1'b0;
                    if (cmd.cmd_steps == 32'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        timer_d = SETUP_RELOAD;
                    end
                end
            end
            S_SETUP: begin
                if (abort)                 state_d = S_DONE;
                else if (timer_q == 32'd0) go_high = 1'b1;
                else                       timer_d = timer_q - 32'd1;
            end
            S_HIGH: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (timer_q == 32'd0) begin
                    state_d = S_LOW;
                    timer_d = period_q - PULSE_LEN - 32'd1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (timer_q == 32'd0) begin
                    if (steps_left_q != 32'd0) go_high = 1'b1;
                    else                       state_d = S_DONE;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A step is issued (or refused at an end stop) on the edge entering HIGH.
        if (go_high) begin
            if (blocked) begin
                state_d     = S_DONE;
                limit_hit_d = 1'b1;
            end else begin
                state_d      = S_HIGH;
                timer_d      = PULSE_RELOAD;
                steps_left_d = steps_left_q - 32'd1;
                position_d   = dir_q ? (position_q + 32'sd1) : (position_q - 32'sd1);
            end
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        step_out      = (state_q == S_HIGH);
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        cmd.cmd_ready = (state_q == S_IDLE) && !reset;
    end

    assign dir_out    = dir_q;
    assign steps_left = steps_left_q;
    assign position   = position_q;

endmodule
